counterdown36_cluster_async_resetn: RTL and testbench

//  36-bit loadable down-counter cluster: three segments of 8, 12 and 16 bits.
//  - Independent mode: segments are three separate down-timers.
//  - Cascade mode: segments chain into one 36-bit down-counter with auto-reload.

---
 rtl/counterdown36_cluster_async_resetn_pkg.sv | 12 +
 rtl/counterdown_load_async_resetn.sv | 43 ++++
 rtl/counterdown36_cluster_async_resetn.sv | 68 ++++++
 tb/tb_counterdown36_cluster_async_resetn.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/counterdown36_cluster_async_resetn_pkg.sv
// Shared constants for the 36-bit down-counter cluster: segment widths and bit offsets.
package counterdown36_cluster_async_resetn_pkg;

  localparam int SEG0_W   = 8;
  localparam int SEG1_W   = 12;
  localparam int SEG2_W   = 16;
  localparam int CNT_N    = SEG0_W + SEG1_W + SEG2_W;
  localparam int SEG0_OFF = 0;
  localparam int SEG1_OFF = SEG0_W;
  localparam int SEG2_OFF = SEG0_W + SEG1_W;

endpackage

// File: rtl/counterdown_load_async_resetn.sv
// One down-counter segment with its own reload register; wraps to reload on a
// decrement at zero and emits a one-cycle registered tc pulse.
module counterdown_load_async_resetn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_zero
);

  logic [WIDTH-1:0] reload;

  assign at_zero = (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '1;
      reload <= '1;
      tc     <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      reload <= load_val;
      tc     <= 1'b0;
    end else if (dec) begin
      // A zero reload value keeps the segment at 0 and pulses tc on every dec.
      if (at_zero) begin
        count <= reload;
        tc    <= 1'b1;
      end else begin
        count <= count - 1'b1;
        tc    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: rtl/counterdown36_cluster_async_resetn.sv
// Three down-counter segments (8/12/16 bits) usable independently or chained
// into one 36-bit counter through a same-cycle combinational borrow chain.
module counterdown36_cluster_async_resetn
  import counterdown36_cluster_async_resetn_pkg::*;
#(
  parameter int W0 = SEG0_W,
  parameter int W1 = SEG1_W,
  parameter int W2 = SEG2_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic                cascade,
  input  logic                load,
  input  logic [W0+W1+W2-1:0] load_val,
  output logic [W0+W1+W2-1:0] count,
  output logic [2:0]          tc,
  output logic                zero
);

  logic [W0-1:0] count0;
  logic [W1-1:0] count1;
  logic [W2-1:0] count2;
  logic [2:0]    at_zero;
  logic [2:0]    dec;

  // In cascade mode a segment only steps when every lower segment is at zero.
  assign dec[0] = en;
  assign dec[1] = cascade ? (dec[0] & at_zero[0]) : en;
  assign dec[2] = cascade ? (dec[1] & at_zero[1]) : en;

  counterdown_load_async_resetn #(.WIDTH(W0)) u_seg0 (
    .clk      (clk),
    .resetn   (resetn),
    .dec      (dec[0]),
    .load     (load),
    .load_val (load_val[W0-1:0]),
    .count    (count0),
    .tc       (tc[0]),
    .at_zero  (at_zero[0])
  );

  counterdown_load_async_resetn #(.WIDTH(W1)) u_seg1 (
    .clk      (clk),
    .resetn   (resetn),
    .dec      (dec[1]),
    .load     (load),
    .load_val (load_val[W0+W1-1:W0]),
    .count    (count1),
    .tc       (tc[1]),
    .at_zero  (at_zero[1])
  );

  counterdown_load_async_resetn #(.WIDTH(W2)) u_seg2 (
    .clk      (clk),
    .resetn   (resetn),
    .dec      (dec[2]),
    .load     (load),
    .load_val (load_val[W0+W1+W2-1:W0+W1]),
    .count    (count2),
    .tc       (tc[2]),
    .at_zero  (at_zero[2])
  );

  assign count = {count2, count1, count0};
  assign zero  = &at_zero;

endmodule

// File: tb/tb_counterdown36_cluster_async_resetn.sv
// Directed and randomized checks of the down-counter cluster against a
// segment-level arithmetic model.
module tb_counterdown36_cluster_async_resetn;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        cascade;
  logic        load;
  logic [35:0] load_val;
  logic [35:0] count;
  logic [2:0]  tc;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-segment value, reload value and last wrap pulses.
  int unsigned m_seg[3];
  int unsigned m_rel[3];
  logic [2:0]  m_tc;
  int unsigned seg_w[3] = '{8, 12, 16};

  counterdown36_cluster_async_resetn dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .cascade  (cascade),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .zero     (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] m_count();
    return {m_seg[2][15:0], m_seg[1][11:0], m_seg[0][7:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_seg[i] = (1 << seg_w[i]) - 1;
      m_rel[i] = m_seg[i];
    end
    m_tc = '0;
  endtask

  // One clock of the counter cluster, described by its rules rather than its registers.
  task automatic model_clock();
    logic borrow;
    logic d;
    if (load) begin
      m_seg[0] = load_val[7:0];
      m_seg[1] = load_val[19:8];
      m_seg[2] = load_val[35:20];
      for (int i = 0; i < 3; i++) m_rel[i] = m_seg[i];
      m_tc = '0;
    end else begin
      borrow = en;
      for (int i = 0; i < 3; i++) begin
        d = cascade ? borrow : en;
        m_tc[i] = 1'b0;
        if (d) begin
          if (m_seg[i] == 0) begin
            m_seg[i] = m_rel[i];
            m_tc[i]  = 1'b1;
          end else begin
            m_seg[i] = m_seg[i] - 1;
            borrow   = 1'b0;
          end
        end else begin
          borrow = 1'b0;
        end
      end
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, count, m_count());
    chk({tag, "_tc"}, {33'd0, tc}, {33'd0, m_tc});
    chk({tag, "_zero"}, {35'd0, zero}, {35'd0, (m_count() == 36'd0)});
  endtask

  // driver: apply current inputs for one clock, then compare 1 ns after the edge
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    chk_model(tag);
  endtask

  task automatic do_load(input logic [35:0] v);
    load = 1'b1; load_val = v;
    step("load");
    load = 1'b0;
  endtask

  task automatic mid_reset();
    #3 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", count, 36'hFFFFFFFFF);
    chk("async_rst_tc", {33'd0, tc}, 36'd0);
    chk("async_rst_zero", {35'd0, zero}, 36'd0);
    #2 resetn = 1'b1;
  endtask

  initial begin
    logic [35:0] v;
    resetn = 1'b0; en = 1'b0; cascade = 1'b0; load = 1'b0; load_val = '0;
    model_reset();

    // 1. reset value
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", count, 36'hFFFFFFFFF);
    chk("reset_tc", {33'd0, tc}, 36'd0);
    chk("reset_zero", {35'd0, zero}, 36'd0);
    @(negedge clk) resetn = 1'b1;
    en = 1'b1;
    repeat (3) step("post_reset");
    mid_reset();

    // 2. independent wrap
    en = 1'b0; cascade = 1'b0;
    do_load(36'h0001_002_03);
    en = 1'b1;
    repeat (4) step("indep");
    chk("indep_wrap_count", count, 36'h0001_001_03);
    chk("indep_wrap_tc", {33'd0, tc}, 36'd5);

    // 3. cascade borrow with zero lower reloads
    en = 1'b0; cascade = 1'b1;
    do_load(36'h0001_000_00);
    en = 1'b1;
    step("casc1");
    chk("casc_borrow_count", count, 36'd0);
    chk("casc_borrow_tc", {33'd0, tc}, 36'd3);
    step("casc2");
    chk("casc_reload_count", count, 36'h0001_000_00);
    chk("casc_reload_tc", {33'd0, tc}, 36'd7);

    // 4. load beats en
    load = 1'b1; load_val = 36'h123456789;
    step("load_prio");
    load = 1'b0;
    chk("load_prio_count", count, 36'h123456789);
    chk("load_prio_tc", {33'd0, tc}, 36'd0);

    // 5. zero reload in both modes
    for (int m = 0; m < 2; m++) begin
      en = 1'b0; cascade = m[0];
      do_load(36'd0);
      en = 1'b1;
      repeat (5) step("zero_rel");
      chk("zero_rel_count", count, 36'd0);
      chk("zero_rel_tc", {33'd0, tc}, 36'd7);
      chk("zero_rel_zero", {35'd0, zero}, 36'd1);
    end

    // 6. en low holds, then cascade toggles mid-run
    en = 1'b0; cascade = 1'b0;
    do_load(36'h0000_010_05);
    repeat (10) step("hold");
    chk("hold_count", count, 36'h0000_010_05);
    chk("hold_tc", {33'd0, tc}, 36'd0);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) cascade = 1'b1;
      if (i == 11) cascade = 1'b0;
      step("toggle");
    end
    mid_reset();

    // randomized traffic; small segment values make wraps and borrows frequent
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        v = {16'($urandom_range(0, 3)), 12'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      else
        v = {$urandom, $urandom};
      load_val = v;
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) cascade = ~cascade;
      step("rand");
      if (i == 200) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
